pwm_symbol_encoder: RTL

PWM_SYMBOL_ENCODER -- requirements
Module: pwm_symbol_encoder

---
 rtl/pwm_symbol_encoder.sv | 116 +++++++++++
 1 files changed

// File: rtl/pwm_symbol_encoder.sv
// Pulse-width symbol encoder: each accepted bit becomes REPEAT symbols of PERIOD clocks
// whose high time encodes the bit, followed by a forced-low GAP before the next bit.
module pwm_symbol_encoder #(
  parameter int PERIOD = 150000,
  parameter int T_ONE  = 112500,
  parameter int T_ZERO = 37500,
  parameter int REPEAT = 6,
  parameter int GAP    = 300000
) (
  input  logic CLOCK_50,
  input  logic RESET_N,
  input  logic DATA_IN,
  input  logic DATA_VALID,
  output logic DATA_READY,
  output logic AUX_OUTPUT,
  output logic BUSY,
  output logic DONE
);

  localparam int CNT_MAX = (PERIOD > GAP) ? PERIOD : GAP;
  localparam int CW      = $clog2(CNT_MAX);
  localparam int RW      = $clog2(REPEAT + 1);

  localparam logic [CW-1:0] PERIOD_LAST = CW'(PERIOD - 1);
  localparam logic [CW-1:0] GAP_LAST    = CW'(GAP - 1);
  localparam logic [CW-1:0] T_ONE_LAST  = CW'(T_ONE - 1);
  localparam logic [CW-1:0] T_ZERO_LAST = CW'(T_ZERO - 1);
  localparam logic [RW-1:0] REP_LAST    = RW'(REPEAT - 1);

  if (!(T_ZERO > 0 && 2 * T_ZERO < PERIOD && 2 * T_ONE > PERIOD &&
        T_ONE < PERIOD && REPEAT >= 1 && GAP >= 1)) begin : g_param_check
    $error("pwm_symbol_encoder: illegal parameter set");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_HIGH,
    S_LOW,
    S_GAP
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] rep_q, rep_d;
  logic          bit_q, bit_d;
  logic          aux_q;
  logic [CW-1:0] t_last;

  // NOTE: every variable gets a default before the case, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rep_d   = rep_q;
    bit_d   = bit_q;
    t_last  = bit_q ? T_ONE_LAST : T_ZERO_LAST;

    case (state_q)
      S_IDLE: begin
        if (DATA_VALID) begin
          bit_d   = DATA_IN;
          cnt_d   = '0;
          rep_d   = '0;
          state_d = S_HIGH;
        end
      end
      S_HIGH: begin
        // The counter keeps running into LOW so one symbol is PERIOD clocks overall.
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == t_last) state_d = S_LOW;
      end
      S_LOW: begin
        if (cnt_q == PERIOD_LAST) begin
          cnt_d   = '0;
          rep_d   = rep_q + 1'b1;
          state_d = (rep_q == REP_LAST) ? S_GAP : S_HIGH;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: reset is sampled on the clock edge, so it also overrides a handshake
  // offered in the same cycle; state updates use non-blocking assignments only.
  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rep_q   <= '0;
      bit_q   <= 1'b0;
      aux_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rep_q   <= rep_d;
      bit_q   <= bit_d;
      aux_q   <= (state_d == S_HIGH);
    end
  end

  assign AUX_OUTPUT = aux_q;
  assign DATA_READY = (state_q == S_IDLE);
  assign BUSY       = (state_q != S_IDLE);
  assign DONE       = (state_q == S_GAP) && (cnt_q == GAP_LAST);

endmodule
